// File: rtl/axi4_burst_pkg.sv
// Shared encodings, AXI constants and helpers for the burst master.
package axi4_burst_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [3:0] CACHE_NORMAL = 4'b0010;

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_XFER}         rstate_t;

  // Ceiling log2, used to derive AxSIZE from the bus width in bytes.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_4k_check.sv
// Flags a burst that would cross a 4KB boundary.
module axi_4k_check
  import axi4_burst_pkg::*;
(
  input  logic [11:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  output logic        o_reject
);

  logic [16:0] w_bytes;
  logic [16:0] w_end;

  // End offset of the burst within its 4KB page, widened so nothing wraps.
  always_comb begin
    w_bytes  = ({9'd0, i_len} + 17'd1) << i_size;
    w_end    = {5'd0, i_addr} + w_bytes;
    o_reject = (w_end > 17'd4096);
  end

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst master with independent write and read engines.
module axi4_burst_master
  import axi4_burst_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned AXI_ADDR_WIDTH = 34,
  parameter int unsigned AXI_ID         = 1,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]   amci_waddr,
  input  logic [7:0]                  amci_wlen,
  input  logic                        amci_write,
  output logic                        amci_widle,
  output logic [1:0]                  amci_wresp,
  input  logic [AXI_DATA_WIDTH-1:0]   wstrm_tdata,
  input  logic                        wstrm_tvalid,
  output logic                        wstrm_tready,
  input  logic [AXI_ADDR_WIDTH-1:0]   amci_raddr,
  input  logic [7:0]                  amci_rlen,
  input  logic                        amci_read,
  output logic                        amci_ridle,
  output logic [1:0]                  amci_rresp,
  output logic [AXI_DATA_WIDTH-1:0]   rstrm_tdata,
  output logic                        rstrm_tvalid,
  input  logic                        rstrm_tready,
  output logic                        rstrm_tlast,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [7:0]                  M_AXI_AWLEN,
  output logic [2:0]                  M_AXI_AWSIZE,
  output logic [1:0]                  M_AXI_AWBURST,
  output logic                        M_AXI_AWLOCK,
  output logic [3:0]                  M_AXI_AWCACHE,
  output logic [3:0]                  M_AXI_AWQOS,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WLAST,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARLOCK,
  output logic [3:0]                  M_AXI_ARCACHE,
  output logic [3:0]                  M_AXI_ARQOS,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int unsigned              BYTES    = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]               AXSIZE   = 3'(clog2(BYTES));
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

  wstate_t r_wstate, w_wnext;
  rstate_t r_rstate, w_rnext;

  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [7:0]                r_wlen, r_rlen, r_wbeat, r_rbeat;
  logic                      r_awvalid, r_arvalid, r_aw_done, r_w_done;
  logic [1:0]                r_wresp, r_rresp;

  logic [AXI_ADDR_WIDTH-1:0] w_waddr_al, w_raddr_al;
  logic w_wreject, w_rreject;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic w_aw_done, w_w_done;

  assign w_waddr_al = amci_waddr & ~LOW_MASK;
  assign w_raddr_al = amci_raddr & ~LOW_MASK;

  axi_4k_check u_wcheck (
    .i_addr   (w_waddr_al[11:0]),
    .i_len    (amci_wlen),
    .i_size   (AXSIZE),
    .o_reject (w_wreject)
  );

  axi_4k_check u_rcheck (
    .i_addr   (w_raddr_al[11:0]),
    .i_len    (amci_rlen),
    .i_size   (AXSIZE),
    .o_reject (w_rreject)
  );

  assign M_AXI_AWID    = AXI_ID_WIDTH'(AXI_ID);
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWLEN   = r_wlen;
  assign M_AXI_AWSIZE  = AXSIZE;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_NORMAL;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wstrm_tdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_ARID    = AXI_ID_WIDTH'(AXI_ID);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARLEN   = r_rlen;
  assign M_AXI_ARSIZE  = AXSIZE;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_NORMAL;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARPROT  = 3'b001;
  assign rstrm_tdata   = M_AXI_RDATA;
  assign amci_wresp    = r_wresp;
  assign amci_rresp    = r_rresp;

  // State registers for both engines.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  // Write engine: W stream pass-through, handshakes and next state.
  // W can finish before AW; r_w_done masks WVALID so no extra beat escapes.
  always_comb begin
    w_wnext      = r_wstate;
    M_AXI_WVALID = 1'b0;
    wstrm_tready = 1'b0;
    M_AXI_BREADY = 1'b0;
    M_AXI_WLAST  = (r_wbeat == r_wlen);
    amci_widle   = (r_wstate == W_IDLE) && !amci_write;
    if (r_wstate == W_XFER && !r_w_done) begin
      M_AXI_WVALID = wstrm_tvalid;
      wstrm_tready = M_AXI_WREADY;
    end
    if (r_wstate == W_RESP) M_AXI_BREADY = 1'b1;
    w_aw_hs   = r_awvalid && M_AXI_AWREADY;
    w_w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    w_aw_done = r_aw_done || w_aw_hs;
    w_w_done  = r_w_done || (w_w_hs && M_AXI_WLAST);
    case (r_wstate)
      W_IDLE:  if (amci_write && !w_wreject) w_wnext = W_XFER;
      W_XFER:  if (w_aw_done && w_w_done) w_wnext = W_RESP;
      W_RESP:  if (M_AXI_BVALID) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  // Write engine datapath: command latch, beat count, response capture.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_awaddr  <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_awvalid <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_wresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: if (amci_write) begin
          if (w_wreject) begin
            r_wresp <= RESP_SLVERR;
          end else begin
            r_awaddr  <= w_waddr_al;
            r_wlen    <= amci_wlen;
            r_wbeat   <= '0;
            r_awvalid <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        W_XFER: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wbeat <= r_wbeat + 8'd1;
            if (M_AXI_WLAST) r_w_done <= 1'b1;
          end
        end
        W_RESP: if (M_AXI_BVALID) r_wresp <= M_AXI_BRESP;
        default: ;
      endcase
    end
  end

  // Read engine: R stream pass-through, handshakes and next state.
  always_comb begin
    w_rnext      = r_rstate;
    M_AXI_RREADY = 1'b0;
    rstrm_tvalid = 1'b0;
    rstrm_tlast  = 1'b0;
    amci_ridle   = (r_rstate == R_IDLE) && !amci_read;
    if (r_rstate == R_XFER) begin
      M_AXI_RREADY = rstrm_tready;
      rstrm_tvalid = M_AXI_RVALID;
      rstrm_tlast  = M_AXI_RLAST;
    end
    w_ar_hs = r_arvalid && M_AXI_ARREADY;
    w_r_hs  = M_AXI_RVALID && M_AXI_RREADY;
    case (r_rstate)
      R_IDLE:  if (amci_read && !w_rreject) w_rnext = R_XFER;
      R_XFER:  if (w_r_hs && M_AXI_RLAST) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read engine datapath: command latch, beat count, worst-response tracking.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_araddr  <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_arvalid <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: if (amci_read) begin
          if (w_rreject) begin
            r_rresp <= RESP_SLVERR;
          end else begin
            r_araddr  <= w_raddr_al;
            r_rlen    <= amci_rlen;
            r_rbeat   <= '0;
            r_arvalid <= 1'b1;
            r_rresp   <= RESP_OKAY;
          end
        end
        R_XFER: begin
          if (w_ar_hs) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_rbeat <= r_rbeat + 8'd1;
            if (M_AXI_RLAST && (r_rbeat != r_rlen)) r_rresp <= RESP_SLVERR;
            else if (M_AXI_RRESP > r_rresp)         r_rresp <= M_AXI_RRESP;
            if (M_AXI_RLAST) r_arvalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
